packet: RTL and testbench

- Single-stage registered packet formatter.
- Combines an 8-bit payload and a 4-bit destination into one 14-bit word: valid flag, parity bit, destination, data.
- Sits between a producer issuing data/destination with a valid strobe and a downstream link/router that samples a flat packet bus.
- No back-pressure; output updates every clock.

---
 rtl/packet_pkg.sv | 24 ++
 rtl/packet_parity.sv | 13 +
 rtl/packet.sv | 43 ++++
 tb/tb_packet.sv | 127 ++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared widths, field positions and packet layout for the packet formatter.
// Parity generation is enabled by defining PACKET_PARITY_EN.
package packet_pkg;

  localparam int DATA_W    = 8;
  localparam int DEST_W    = 4;
  localparam int PKT_W     = DATA_W + DEST_W + 2;
  localparam int VALID_BIT = 13;
  localparam int PAR_BIT   = 12;

  typedef struct packed {
    logic              valid;
    logic              parity;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } packet_t;

  // Even parity over destination and payload, so bits [12:0] carry an even count of ones.
  function automatic logic calc_parity(input logic [DEST_W-1:0] dest,
                                       input logic [DATA_W-1:0] data);
    return ^{dest, data};
  endfunction

endpackage

// File: rtl/packet_parity.sv
// Combinational even-parity generator for the destination/payload fields.
// Only instantiated when PACKET_PARITY_EN is defined.
module packet_parity
  import packet_pkg::*;
(
  input  logic [DEST_W-1:0] dest,
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = calc_parity(dest, data);

endmodule

// File: rtl/packet.sv
// Single-stage registered packet formatter: {valid, parity, dest, data}.
// Define PACKET_PARITY_EN to generate the parity bit; otherwise it is tied to 0.
module packet
  import packet_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic              valid_in,
  output logic [PKT_W-1:0]  packet_out
);

  packet_t pkt_r;
  logic    parity_s;

`ifdef PACKET_PARITY_EN
  packet_parity u_parity (
    .dest   (dest_in),
    .data   (data_in),
    .parity (parity_s)
  );
`else
  assign parity_s = 1'b0;
`endif

  // Output register: capture a new packet on valid, otherwise drop only the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_r <= packet_t'({PKT_W{1'b0}});
    end else if (valid_in) begin
      pkt_r.valid  <= 1'b1;
      pkt_r.parity <= parity_s;
      pkt_r.dest   <= dest_in;
      pkt_r.data   <= data_in;
    end else begin
      pkt_r.valid  <= 1'b0;
    end
  end

  assign packet_out = pkt_r;

endmodule

// File: tb/tb_packet.sv
// Directed and random self-checking bench for the packet formatter.
// Expected values follow PACKET_PARITY_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_packet;
  import packet_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] data_in = 8'h00;
  logic [DEST_W-1:0] dest_in = 4'h0;
  logic              valid_in = 1'b0;
  logic [PKT_W-1:0]  packet_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PKT_W-1:0] exp_m = 14'h0000;

  packet dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .dest_in    (dest_in),
    .valid_in   (valid_in),
    .packet_out (packet_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [PKT_W-1:0] obs,
                          input logic [PKT_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_parity(input logic [3:0] dst, input logic [7:0] dat);
`ifdef PACKET_PARITY_EN
    return ^{dst, dat};
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [13:0] model(input logic [13:0] prev, input logic v,
                                        input logic [3:0] dst, input logic [7:0] dat);
    if (v) return {1'b1, ref_parity(dst, dat), dst, dat};
    else   return {1'b0, prev[12:0]};
  endfunction

  // Drive one cycle at the falling edge, then compare just after the rising edge.
  task automatic step(input string tag, input logic v, input logic [3:0] dst,
                      input logic [7:0] dat);
    @(negedge clk);
    valid_in = v;
    dest_in  = dst;
    data_in  = dat;
    @(posedge clk);
    #1;
    exp_m = model(exp_m, v, dst, dat);
    check_eq(tag, packet_out, exp_m);
  endtask

  logic [13:0] exp_p2, exp_idle;

  initial begin
`ifdef PACKET_PARITY_EN
    exp_p2   = 14'h3755;
    exp_idle = 14'h1755;
`else
    exp_p2   = 14'h2755;
    exp_idle = 14'h0755;
`endif
    // Asynchronous reset before any clock edge, then held with inputs toggling.
    #1 rst_n = 1'b0;
    #1 check_eq("rst_async", packet_out, 14'h0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      dest_in  = 4'(i + 5);
      data_in  = 8'(8'h3C ^ 8'(i));
      @(posedge clk);
      #1 check_eq("rst_hold", packet_out, 14'h0000);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b1;
    exp_m    = 14'h0000;

    step("pkt_a5", 1'b1, 4'h3, 8'hA5);
    check_eq("pkt_a5_const", packet_out, 14'h23A5);
    step("pkt_55", 1'b1, 4'h7, 8'h55);
    check_eq("pkt_55_const", packet_out, exp_p2);
    for (int i = 0; i < 10; i++) begin
      step("idle", 1'b0, 4'(4'hC ^ 4'(i)), 8'(8'h3E + 8'(i)));
      check_eq("idle_const", packet_out, exp_idle);
    end

    // Mid-stream reset pulse while the 7/55 packet is showing.
    step("pkt_55_again", 1'b1, 4'h7, 8'h55);
    @(negedge clk);
    #2 rst_n = 1'b0;
    valid_in = 1'b0;
    #1 check_eq("rst_mid", packet_out, 14'h0000);
    @(posedge clk);
    #1 check_eq("rst_mid_hold", packet_out, 14'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    exp_m = 14'h0000;
    step("pkt_ff", 1'b1, 4'hF, 8'hFF);
    check_eq("pkt_ff_const", packet_out, 14'h2FFF);

    for (int i = 0; i < 1000; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
`ifdef PACKET_PARITY_EN
      check_eq("even_ones", {13'h0000, ^packet_out[12:0]}, 14'h0000);
`else
      check_eq("par_zero", {13'h0000, packet_out[12]}, 14'h0000);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
